// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR  : bubble instruction (sll $0,$0,0) inserted on squash
//   WORD_BYTES : instruction size in bytes, the sequential PC step
//   if_id_t    : IF/ID pipeline register bundle {instr, pc4, valid}
// ----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_stage_pc_reg.sv
// ----------------------------------------------------------------------------
// if_stage_pc_reg
// Program counter register with its next-PC selection.
// Ports:
//   i_clk         : clock, rising edge
//   i_rst_n       : asynchronous active-low reset, loads RESET_PC
//   i_stall       : hold the PC
//   i_redirect    : load the (aligned) redirect target; beats i_stall
//   i_redirect_pc : branch/jump target byte address
//   o_pc          : current fetch PC, always word aligned
//   o_pc_plus4    : o_pc + 4, also used for the IF/ID pc4 field
// ----------------------------------------------------------------------------
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    // Low two bits are cleared so the PC can never become misaligned,
    // whatever target or reset value is supplied.
    localparam logic [31:0] ALIGN_MASK   = ~32'h0000_0003;
    localparam logic [31:0] RESET_PC_AL  = RESET_PC & ALIGN_MASK;

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] w_target;

    assign w_target   = i_redirect_pc & ALIGN_MASK;
    assign o_pc_plus4 = r_pc + 32'(WORD_BYTES);
    assign o_pc       = r_pc;

    // Redirect wins over stall; otherwise step sequentially (wraps mod 2^32).
    always_comb begin
        w_next_pc = o_pc_plus4;
        if (i_redirect) begin
            w_next_pc = w_target;
        end else if (i_stall) begin
            w_next_pc = r_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC_AL;
        end else begin
            r_pc <= w_next_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: PC, instruction-memory address, IF/ID register
// and a count of instructions accepted into IF/ID.
// Ports:
//   i_clk, i_rst_n  : clock (rising edge), asynchronous active-low reset
//   i_stall         : hold PC and IF/ID
//   i_flush         : squash the instruction being latched into IF/ID
//   i_redirect      : taken branch/jump; also squashes the IF/ID load
//   i_redirect_pc   : target byte address (aligned down to a word)
//   o_imem_addr     : byte address to instruction memory (combinational read)
//   i_imem_instr    : instruction returned by memory in the same cycle
//   o_pc            : current fetch PC
//   o_if_id_instr   : registered instruction for decode
//   o_if_id_pc4     : registered PC+4 of that instruction
//   o_if_id_valid   : 1 = real instruction, 0 = bubble
//   o_fetch_count   : instructions accepted into IF/ID (mod 2^16)
// ----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 7,
    parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_redirect,
    input  logic [31:0]        i_redirect_pc,
    output logic [IMEM_AW-1:0] o_imem_addr,
    input  logic [31:0]        i_imem_instr,
    output logic [31:0]        o_pc,
    output logic [31:0]        o_if_id_instr,
    output logic [31:0]        o_if_id_pc4,
    output logic               o_if_id_valid,
    output logic [15:0]        o_fetch_count
);

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_squash;
    logic        w_load;
    if_id_t      r_if_id;
    logic [15:0] r_fetch_count;

    if_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_pc          (w_pc),
        .o_pc_plus4    (w_pc_plus4)
    );

    // Addresses beyond the memory simply alias through truncation.
    assign o_imem_addr = w_pc[IMEM_AW-1:0];
    assign o_pc        = w_pc;

    // A redirect means the instruction now being fetched is on the wrong
    // path, so it is squashed exactly like an explicit flush. Squash beats
    // stall so a stalled-and-flushed slot still becomes a bubble.
    assign w_squash = i_flush | i_redirect;
    assign w_load   = ~w_squash & ~i_stall;

    // The pc4 field is deliberately left untouched on a squash.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_id.instr <= NOP_INSTR;
            r_if_id.pc4   <= 32'h0000_0000;
            r_if_id.valid <= 1'b0;
        end else if (w_squash) begin
            r_if_id.instr <= NOP_INSTR;
            r_if_id.valid <= 1'b0;
        end else if (w_load) begin
            r_if_id.instr <= i_imem_instr;
            r_if_id.pc4   <= w_pc_plus4;
            r_if_id.valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_count <= 16'h0000;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 16'h0001;
        end
    end

    assign o_if_id_instr = r_if_id.instr;
    assign o_if_id_pc4   = r_if_id.pc4;
    assign o_if_id_valid = r_if_id.valid;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage with a small combinational instruction memory.
// ----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rstN;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [6:0]  imemAddr;
    logic [31:0] imemInstr;
    logic [31:0] pc;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc4;
    logic        ifIdValid;
    logic [15:0] fetchCount;

    int passCount  = 0;
    int totalCount = 0;

    logic [31:0] mem [0:31];

    if_stage dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc),
        .o_imem_addr   (imemAddr),
        .i_imem_instr  (imemInstr),
        .o_pc          (pc),
        .o_if_id_instr (ifIdInstr),
        .o_if_id_pc4   (ifIdPc4),
        .o_if_id_valid (ifIdValid),
        .o_fetch_count (fetchCount)
    );

    // 128-byte memory, word indexed, read in the same cycle.
    assign imemInstr = mem[imemAddr[6:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every word holds a recognisable tag of its own word index.
    function automatic logic [31:0] memWord(input int idx);
        logic [7:0] low;
        low = 8'(idx);
        return {16'hC0DE, 8'h00, low};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            $error("[TB] %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [31:0] expPc,
                              input logic [31:0] expInstr, input logic [31:0] expPc4,
                              input logic expValid, input logic [15:0] expCount);
        checkOutput({tag, ".pc"},    pc,               expPc);
        checkOutput({tag, ".instr"}, ifIdInstr,        expInstr);
        checkOutput({tag, ".pc4"},   ifIdPc4,          expPc4);
        checkOutput({tag, ".valid"}, 32'(ifIdValid),   32'(expValid));
        checkOutput({tag, ".count"}, 32'(fetchCount),  32'(expCount));
    endtask

    task automatic applyStimulus(input logic s, input logic f, input logic r,
                                 input logic [31:0] target);
        stall      = s;
        flush      = f;
        redirect   = r;
        redirectPc = target;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = memWord(i);
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        #7;
        checkState("reset", 32'h0, NOP, 32'h0, 1'b0, 16'd0);
        checkOutput("reset.imemAddr", 32'(imemAddr), 32'h0);
        rstN = 1'b1;

        // Sequential fetch
        stepEdge();
        checkState("seq1", 32'h04, memWord(0), 32'h04, 1'b1, 16'd1);
        stepEdge();
        checkState("seq2", 32'h08, memWord(1), 32'h08, 1'b1, 16'd2);
        stepEdge();
        checkState("seq3", 32'h0C, memWord(2), 32'h0C, 1'b1, 16'd3);
        stepEdge();
        checkState("seq4", 32'h10, memWord(3), 32'h10, 1'b1, 16'd4);

        // Fresh start, then stall two edges at pc=8
        rstN = 1'b0;
        #1;
        checkState("rst2", 32'h0, NOP, 32'h0, 1'b0, 16'd0);
        #1;
        rstN = 1'b1;
        stepEdge();
        stepEdge();
        checkState("preStall", 32'h08, memWord(1), 32'h08, 1'b1, 16'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepEdge();
        checkState("stall1", 32'h08, memWord(1), 32'h08, 1'b1, 16'd2);
        stepEdge();
        checkState("stall2", 32'h08, memWord(1), 32'h08, 1'b1, 16'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepEdge();
        checkState("unstall", 32'h0C, memWord(2), 32'h0C, 1'b1, 16'd3);

        // Redirect to a misaligned target at pc=12
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0022);
        stepEdge();
        checkState("redir", 32'h20, NOP, 32'h0C, 1'b0, 16'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepEdge();
        checkState("afterRedir", 32'h24, memWord(8), 32'h24, 1'b1, 16'd4);

        // Stall + flush + redirect together
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        stepEdge();
        checkState("allThree", 32'h40, NOP, 32'h24, 1'b0, 16'd4);
        checkOutput("allThree.imemAddr", 32'(imemAddr), 32'h40);

        // Flush alone: PC advances, slot becomes a bubble
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        stepEdge();
        checkState("flush", 32'h44, NOP, 32'h24, 1'b0, 16'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepEdge();
        checkState("afterFlush", 32'h48, memWord(17), 32'h48, 1'b1, 16'd5);

        // Aliasing past the end of the 128-byte memory
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_007C);
        stepEdge();
        checkState("to7C", 32'h7C, NOP, 32'h48, 1'b0, 16'd5);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepEdge();
        checkState("at80", 32'h80, memWord(31), 32'h80, 1'b1, 16'd6);
        checkOutput("at80.imemAddr", 32'(imemAddr), 32'h00);
        stepEdge();
        checkState("at84", 32'h84, memWord(0), 32'h84, 1'b1, 16'd7);

        // Async reset mid-cycle at pc=0x14 with a redirect pending
        rstN = 1'b0;
        #1;
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) stepEdge();
        checkState("pre14", 32'h14, memWord(4), 32'h14, 1'b1, 16'd5);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0060);
        #2;
        rstN = 1'b0;
        #1;
        checkState("asyncRst", 32'h0, NOP, 32'h0, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        rstN = 1'b1;
        stepEdge();
        checkState("resume", 32'h04, memWord(0), 32'h04, 1'b1, 16'd1);

        // fetch_count wrap from 16'hFFFF to 0
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        checkOutput("countFFFF", 32'(fetchCount), 32'h0000_FFFF);
        stepEdge();
        checkOutput("countWrap", 32'(fetchCount), 32'h0000_0000);
        checkOutput("wrap.valid", 32'(ifIdValid), 32'h1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_AW, default 7: instruction-memory byte-address width.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0000: bubble instruction (sll $0,$0,0).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  hazard unit hold of PC and IF/ID register.
REQ-007 flush  input  1  squash the instruction being latched into IF/ID.
REQ-008 redirect  input  1  taken branch/jump from a later stage.
REQ-009 redirect_pc  input  32  branch/jump target byte address.
REQ-010 imem_addr  output  IMEM_AW  byte address to instruction memory (combinational read).
REQ-011 imem_instr  input  32  instruction returned by memory, same cycle.
REQ-012 pc  output  32  current fetch PC.
REQ-013 if_id_instr  output  32  registered instruction for decode.
REQ-014 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-015 if_id_valid  output  1  1 = if_id_instr is a real fetched instruction, 0 = bubble.
REQ-016 fetch_count  output  16  count of instructions accepted into IF/ID.

Function
REQ-017 imem_addr SHALL equal pc[IMEM_AW-1:0] combinationally; pc SHALL be word aligned (pc[1:0]==0) at all times.
REQ-018 Next-PC priority SHALL be: redirect -> {redirect_pc[31:2],2'b00}; else stall -> hold; else pc+4 (32-bit modulo wrap).
REQ-019 redirect SHALL override stall in the same cycle.
REQ-020 IF/ID update priority SHALL be: flush or redirect -> instr=NOP_INSTR, pc4 unchanged, valid=0; else stall -> hold all IF/ID fields; else load imem_instr, pc+4, valid=1.
REQ-021 flush with stall in the same cycle SHALL produce a bubble (flush wins).
REQ-022 Latency: instruction at address A SHALL appear on if_id_instr exactly one rising edge after pc==A with stall=flush=redirect=0.
REQ-023 fetch_count SHALL increment by 1 (modulo 2^16 wrap) on every edge where IF/ID loads with valid=1; otherwise hold.
REQ-024 pc beyond the memory range SHALL alias via imem_addr truncation; no error signalled.
REQ-025 redirect_pc[1:0]!=0 SHALL be silently aligned down (REQ-018).
REQ-026 Inputs stall/flush/redirect SHALL be sampled only at the rising edge; no combinational path from them to any output except through registers.

Reset
REQ-027 rst_n low SHALL immediately set pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, fetch_count=0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL discard any pending redirect/stall; first fetch after release SHALL be from RESET_PC at the first rising edge with rst_n high.
REQ-029 Reset deassertion SHALL be synchronised externally; block assumes no edge-coincident release.

Structure
REQ-030 Shared package SHALL hold NOP_INSTR, word size (4), and the IF/ID register bundle typedef {instr, pc4, valid}.
REQ-031 One sub-module SHALL be natural: pc_reg (PC register plus next-PC mux); IF/ID register lives in if_stage top.
REQ-032 if_stage SHALL connect directly to the existing instruction memory port (7-bit address in, 32-bit instruction out) without glue.

Verification
REQ-033 Sequential fetch: reset then 4 free edges -> pc 0,4,8,12,16; if_id_pc4 4,8,12,16; valid=1 from first edge; fetch_count=4.
REQ-034 Stall: stall=1 for 2 edges at pc=8 -> pc stays 8, if_id fields held, fetch_count unchanged; release -> pc=12 next edge.
REQ-035 Redirect: redirect=1, redirect_pc=32'h0000_0022 at pc=12 -> pc=32'h20 next edge, if_id_valid=0, if_id_instr=NOP; following edge loads word at 0x20.
REQ-036 Simultaneous: stall=1, flush=1, redirect=1, redirect_pc=0x40 -> pc=0x40, IF/ID bubble; imem_addr=0x40.
REQ-037 Wrap/alias: pc=0x7C -> next pc=0x80, imem_addr=0x00; fetch_count from 16'hFFFF wraps to 0.
REQ-038 Async reset: assert rst_n low between edges at pc=0x14 -> outputs reach reset values before next edge; release -> fetch resumes at 0.
